mem_bus_arbiter: RTL and testbench

- Shares one memory port between the CPU instruction-fetch channel (read-only) and the CPU data channel (load/store).
- Sits between the multi-cycle CPU core and the memory/bus interface.
- Grants one transaction at a time with round-robin fairness, and routes the read response back to the granted master.
- Uses valid/ack handshakes on every channel, matching the core's channels.

---
 rtl/mem_bus_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares a single memory port between the CPU instruction-fetch channel
//   (read-only) and the CPU data channel (load/store). One transaction is in
//   flight at a time; ties are broken round-robin and read responses are
//   routed back to the master that owns the transaction.
//
// Optional build macro:
//   ARB_PERF_CNT_EN - adds grant and contention performance counters.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   i_req_*              fetch request channel (valid/addr in, ack out)
//   i_rdata_*            fetch response channel (valid out, ack in)
//   d_*                  data request channel (addr/wen/ren/wdata/wstrb in,
//                        req_ack out) and load response channel
//   rsp_rdata            response data shared by both masters (= m_rdata)
//   m_*                  memory-side request/response channel
//   inst_grant_cnt,      grant counts per master and contended-cycle count
//   data_grant_cnt,      (present only with ARB_PERF_CNT_EN)
//   conflict_cnt
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    // Instruction fetch channel
    input  logic                    i_req_valid,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    output logic                    i_req_ack,
    output logic                    i_rdata_valid,
    input  logic                    i_rdata_ack,

    // Data channel
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic                    d_wen,
    input  logic                    d_ren,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_req_ack,
    output logic                    d_rdata_valid,
    input  logic                    d_rdata_ack,

    // Shared response data
    output logic [DATA_WIDTH-1:0]   rsp_rdata,

    // Memory channel
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic                    m_wen,
    output logic                    m_ren,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_req_ack,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic                    m_rdata_valid,
    output logic                    m_rdata_ack
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]             inst_grant_cnt,
    output logic [31:0]             data_grant_cnt,
    output logic [31:0]             conflict_cnt
`endif
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        REQ  = 3'b010,
        RESP = 3'b100
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    state_t state,      state_nxt;
    owner_t owner,      owner_nxt;
    owner_t last_grant, last_grant_nxt;

    logic inst_pend;
    logic data_pend;

    // Pending-request decode for both masters
    assign inst_pend = i_req_valid;
    assign data_pend = d_wen | d_ren;

    // Read data is broadcast; the valid signals select the consumer
    assign rsp_rdata = m_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            last_grant <= OWN_DATA;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next-state and output decode; m_* are forced low outside REQ so no
    // master input reaches the memory port while arbitrating.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;

        i_req_ack      = 1'b0;
        i_rdata_valid  = 1'b0;
        d_req_ack      = 1'b0;
        d_rdata_valid  = 1'b0;
        m_addr         = '0;
        m_wen          = 1'b0;
        m_ren          = 1'b0;
        m_wdata        = '0;
        m_wstrb        = '0;
        m_rdata_ack    = 1'b0;

        case (state)
            IDLE: begin
                if (inst_pend && data_pend) begin
                    // Round-robin: the master that did not go last wins
                    owner_nxt = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
                    state_nxt = REQ;
                end else if (inst_pend) begin
                    owner_nxt = OWN_INST;
                    state_nxt = REQ;
                end else if (data_pend) begin
                    owner_nxt = OWN_DATA;
                    state_nxt = REQ;
                end
            end

            REQ: begin
                if (owner == OWN_INST) begin
                    m_addr    = i_req_addr;
                    m_ren     = 1'b1;
                    i_req_ack = m_req_ack;
                    if (m_req_ack) begin
                        state_nxt = RESP;
                    end
                end else begin
                    // wen and ren together resolve to a store
                    m_addr    = d_addr;
                    m_wen     = d_wen;
                    m_ren     = d_ren & ~d_wen;
                    m_wdata   = d_wdata;
                    m_wstrb   = d_wstrb;
                    d_req_ack = m_req_ack;
                    if (m_req_ack) begin
                        if (d_wen) begin
                            state_nxt      = IDLE;
                            last_grant_nxt = OWN_DATA;
                        end else begin
                            state_nxt = RESP;
                        end
                    end
                end
            end

            RESP: begin
                if (owner == OWN_INST) begin
                    i_rdata_valid = m_rdata_valid;
                    m_rdata_ack   = i_rdata_ack;
                end else begin
                    d_rdata_valid = m_rdata_valid;
                    m_rdata_ack   = d_rdata_ack;
                end
                if (m_rdata_valid && m_rdata_ack) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = owner;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef ARB_PERF_CNT_EN
    logic grant_inst;
    logic grant_data;
    logic conflict;

    // Grant strobes fire on the IDLE->REQ transition only
    assign grant_inst = (state == IDLE) && (state_nxt == REQ) && (owner_nxt == OWN_INST);
    assign grant_data = (state == IDLE) && (state_nxt == REQ) && (owner_nxt == OWN_DATA);

    // A cycle is contended when some pending master is not the one being served
    assign conflict = ((state == IDLE) && inst_pend && data_pend) ||
                      ((state != IDLE) && (owner == OWN_INST) && data_pend) ||
                      ((state != IDLE) && (owner == OWN_DATA) && inst_pend);

    // Free-running counters, wrap naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_grant_cnt <= 32'd0;
            data_grant_cnt <= 32'd0;
            conflict_cnt   <= 32'd0;
        end else begin
            if (grant_inst) begin
                inst_grant_cnt <= inst_grant_cnt + 32'd1;
            end
            if (grant_data) begin
                data_grant_cnt <= data_grant_cnt + 32'd1;
            end
            if (conflict) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter. Inputs change 1 ns after each rising
//   edge and outputs are sampled 1 ns later, mid-cycle.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_req_ack;
    logic        i_rdata_valid;
    logic        i_rdata_ack;
    logic [31:0] d_addr;
    logic        d_wen;
    logic        d_ren;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_req_ack;
    logic        d_rdata_valid;
    logic        d_rdata_ack;
    logic [31:0] rsp_rdata;
    logic [31:0] m_addr;
    logic        m_wen;
    logic        m_ren;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_req_ack;
    logic [31:0] m_rdata;
    logic        m_rdata_valid;
    logic        m_rdata_ack;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] inst_grant_cnt;
    logic [31:0] data_grant_cnt;
    logic [31:0] conflict_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    mem_bus_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid    (i_req_valid),
        .i_req_addr     (i_req_addr),
        .i_req_ack      (i_req_ack),
        .i_rdata_valid  (i_rdata_valid),
        .i_rdata_ack    (i_rdata_ack),
        .d_addr         (d_addr),
        .d_wen          (d_wen),
        .d_ren          (d_ren),
        .d_wdata        (d_wdata),
        .d_wstrb        (d_wstrb),
        .d_req_ack      (d_req_ack),
        .d_rdata_valid  (d_rdata_valid),
        .d_rdata_ack    (d_rdata_ack),
        .rsp_rdata      (rsp_rdata),
        .m_addr         (m_addr),
        .m_wen          (m_wen),
        .m_ren          (m_ren),
        .m_wdata        (m_wdata),
        .m_wstrb        (m_wstrb),
        .m_req_ack      (m_req_ack),
        .m_rdata        (m_rdata),
        .m_rdata_valid  (m_rdata_valid),
        .m_rdata_ack    (m_rdata_ack)
`ifdef ARB_PERF_CNT_EN
        ,
        .inst_grant_cnt (inst_grant_cnt),
        .data_grant_cnt (data_grant_cnt),
        .conflict_cnt   (conflict_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req_valid   = 1'b0;
        i_req_addr    = 32'h0;
        i_rdata_ack   = 1'b0;
        d_addr        = 32'h0;
        d_wen         = 1'b0;
        d_ren         = 1'b0;
        d_wdata       = 32'h0;
        d_wstrb       = 4'h0;
        d_rdata_ack   = 1'b0;
        m_req_ack     = 1'b0;
        m_rdata       = 32'h0;
        m_rdata_valid = 1'b0;
    endtask

    // Every arbiter output quiet
    task automatic chk_quiet(input string tag);
        chk32({tag, ".m_addr"},  m_addr, 32'h0);
        chk1 ({tag, ".m_wen"},   m_wen, 1'b0);
        chk1 ({tag, ".m_ren"},   m_ren, 1'b0);
        chk32({tag, ".m_wdata"}, m_wdata, 32'h0);
        chk32({tag, ".m_wstrb"}, 32'(m_wstrb), 32'h0);
        chk1 ({tag, ".i_req_ack"},     i_req_ack, 1'b0);
        chk1 ({tag, ".d_req_ack"},     d_req_ack, 1'b0);
        chk1 ({tag, ".i_rdata_valid"}, i_rdata_valid, 1'b0);
        chk1 ({tag, ".d_rdata_valid"}, d_rdata_valid, 1'b0);
        chk1 ({tag, ".m_rdata_ack"},   m_rdata_ack, 1'b0);
    endtask

    // Lone fetch: IDLE, REQ with immediate ack, RESP with immediate data
    task automatic inst_read(input string tag, input logic [31:0] addr, input logic [31:0] data);
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        #1;
        chk1({tag, ".idle_m_ren"}, m_ren, 1'b0);
        next_cycle();
        m_req_ack = 1'b1;
        #1;
        chk1 ({tag, ".i_req_ack"}, i_req_ack, 1'b1);
        chk32({tag, ".m_addr"},    m_addr, addr);
        next_cycle();
        i_req_valid   = 1'b0;
        m_req_ack     = 1'b0;
        m_rdata_valid = 1'b1;
        m_rdata       = data;
        i_rdata_ack   = 1'b1;
        #1;
        chk1 ({tag, ".i_rdata_valid"}, i_rdata_valid, 1'b1);
        chk32({tag, ".rsp_rdata"},     rsp_rdata, data);
        next_cycle();
        clear_inputs();
    endtask

    // Lone store, optionally with ren also raised; must not enter RESP
    task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic with_ren);
        d_wen   = 1'b1;
        d_ren   = with_ren;
        d_addr  = addr;
        d_wdata = data;
        d_wstrb = strb;
        #1;
        chk1({tag, ".idle_m_wen"}, m_wen, 1'b0);
        next_cycle();
        m_req_ack = 1'b1;
        #1;
        chk1 ({tag, ".m_wen"},     m_wen, 1'b1);
        chk1 ({tag, ".m_ren"},     m_ren, 1'b0);
        chk32({tag, ".m_addr"},    m_addr, addr);
        chk32({tag, ".m_wdata"},   m_wdata, data);
        chk32({tag, ".m_wstrb"},   32'(m_wstrb), 32'(strb));
        chk1 ({tag, ".d_req_ack"}, d_req_ack, 1'b1);
        chk1 ({tag, ".i_req_ack"}, i_req_ack, 1'b0);
        next_cycle();
        clear_inputs();
        // A stray response must be ignored because the arbiter is back in IDLE
        m_rdata_valid = 1'b1;
        d_rdata_ack   = 1'b1;
        #1;
        chk1({tag, ".no_resp_valid"}, d_rdata_valid, 1'b0);
        chk1({tag, ".no_resp_ack"},   m_rdata_ack, 1'b0);
        clear_inputs();
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        chk_quiet("reset");

        // Inst only: ack in cycle 2, response in cycle 3
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0000_0100;
        m_req_ack   = 1'b1;
        #1;
        chk1("t1.idle_m_ren",     m_ren, 1'b0);
        chk1("t1.idle_i_req_ack", i_req_ack, 1'b0);
        next_cycle();
        #1;
        chk1 ("t1.m_ren",     m_ren, 1'b1);
        chk1 ("t1.m_wen",     m_wen, 1'b0);
        chk32("t1.m_addr",    m_addr, 32'h0000_0100);
        chk1 ("t1.i_req_ack", i_req_ack, 1'b1);
        chk1 ("t1.d_req_ack", d_req_ack, 1'b0);
        next_cycle();
        i_req_valid   = 1'b0;
        m_req_ack     = 1'b0;
        m_rdata_valid = 1'b1;
        m_rdata       = 32'hDEAD_BEEF;
        i_rdata_ack   = 1'b1;
        #1;
        chk1 ("t1.i_rdata_valid", i_rdata_valid, 1'b1);
        chk32("t1.rsp_rdata",     rsp_rdata, 32'hDEAD_BEEF);
        chk1 ("t1.m_rdata_ack",   m_rdata_ack, 1'b1);
        chk1 ("t1.d_rdata_valid", d_rdata_valid, 1'b0);
        chk1 ("t1.d_req_ack",     d_req_ack, 1'b0);
        next_cycle();
        clear_inputs();
        #1;
        chk_quiet("t1.done");
        next_cycle();

        // Store only
        store("t2", 32'h0000_0204, 32'h1122_3344, 4'b0100, 1'b0);

        // Both pending repeatedly: last grant was data, so inst leads and they alternate
        for (int k = 0; k < 6; k++) begin
            logic        exp_inst;
            logic [31:0] ia;
            logic [31:0] da;
            exp_inst    = (k % 2 == 0);
            ia          = 32'h0000_0400 + 32'(k * 4);
            da          = 32'h0000_0300 + 32'(k * 4);
            i_req_valid = 1'b1;
            i_req_addr  = ia;
            d_ren       = 1'b1;
            d_addr      = da;
            #1;
            chk1("t3.idle_m_ren", m_ren, 1'b0);
            next_cycle();
            m_req_ack = 1'b1;
            #1;
            chk1 ("t3.i_req_ack", i_req_ack, exp_inst);
            chk1 ("t3.d_req_ack", d_req_ack, ~exp_inst);
            chk32("t3.m_addr",    m_addr, exp_inst ? ia : da);
            next_cycle();
            if (exp_inst) i_req_valid = 1'b0;
            else          d_ren       = 1'b0;
            m_req_ack     = 1'b0;
            m_rdata_valid = 1'b1;
            m_rdata       = 32'h0000_A000 + 32'(k);
            i_rdata_ack   = 1'b1;
            d_rdata_ack   = 1'b1;
            #1;
            chk1 ("t3.i_rdata_valid", i_rdata_valid, exp_inst);
            chk1 ("t3.d_rdata_valid", d_rdata_valid, ~exp_inst);
            chk32("t3.rsp_rdata",     rsp_rdata, 32'h0000_A000 + 32'(k));
            next_cycle();
            clear_inputs();
        end

        // Data load with stalled memory; inst waits meanwhile
        d_ren  = 1'b1;
        d_addr = 32'h0000_0600;
        #1;
        next_cycle();
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0000_0500;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk32("t4.stall_m_addr", m_addr, 32'h0000_0600);
            chk1 ("t4.stall_m_ren",  m_ren, 1'b1);
            chk1 ("t4.stall_d_ack",  d_req_ack, 1'b0);
            chk1 ("t4.stall_i_ack",  i_req_ack, 1'b0);
            next_cycle();
        end
        m_req_ack = 1'b1;
        #1;
        chk1("t4.d_req_ack", d_req_ack, 1'b1);
        chk1("t4.i_req_ack", i_req_ack, 1'b0);
        next_cycle();
        d_ren         = 1'b0;
        m_req_ack     = 1'b0;
        m_rdata_valid = 1'b1;
        m_rdata       = 32'hCAFE_0000;
        i_rdata_ack   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk1("t4.d_rdata_valid", d_rdata_valid, 1'b1);
            chk1("t4.i_rdata_valid", i_rdata_valid, 1'b0);
            chk1("t4.m_rdata_ack",   m_rdata_ack, 1'b0);
            next_cycle();
        end
        d_rdata_ack = 1'b1;
        #1;
        chk1("t4.m_rdata_ack_final", m_rdata_ack, 1'b1);
        next_cycle();

        // Waiting fetch granted, then reset hits during RESP
        i_rdata_ack   = 1'b0;
        d_rdata_ack   = 1'b0;
        m_rdata_valid = 1'b0;
        i_req_addr    = 32'h0000_0700;
        #1;
        next_cycle();
        m_req_ack = 1'b1;
        #1;
        chk1 ("t5.i_req_ack", i_req_ack, 1'b1);
        chk32("t5.m_addr",    m_addr, 32'h0000_0700);
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        rst           = 1'b0;
        m_rdata_valid = 1'b1;
        i_rdata_ack   = 1'b1;
        #1;
        chk_quiet("t5.after_rst");
        chk32("t5.rsp_rdata", rsp_rdata, 32'h0);
        clear_inputs();
        next_cycle();
        inst_read("t5.refetch", 32'h0000_0800, 32'h1234_5678);
        #1;
        chk_quiet("t5.done");
        next_cycle();

        // Store with ren also high behaves as a write
        store("t6", 32'h0000_0A00, 32'h5566_7788, 4'b1111, 1'b1);

`ifdef ARB_PERF_CNT_EN
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        chk32("t7.rst_inst_cnt", inst_grant_cnt, 32'd0);
        chk32("t7.rst_data_cnt", data_grant_cnt, 32'd0);
        chk32("t7.rst_conf_cnt", conflict_cnt, 32'd0);
        inst_read("t7.r0", 32'h0000_1000, 32'h0000_0001);
        inst_read("t7.r1", 32'h0000_1004, 32'h0000_0002);
        inst_read("t7.r2", 32'h0000_1008, 32'h0000_0003);
        store("t7.s0", 32'h0000_2000, 32'h0000_00AA, 4'b0001, 1'b0);
        // Contended grant: IDLE and REQ both count as conflict cycles
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0000_100C;
        d_ren       = 1'b1;
        d_addr      = 32'h0000_2004;
        #1;
        next_cycle();
        m_req_ack = 1'b1;
        #1;
        chk1("t7.i_req_ack", i_req_ack, 1'b1);
        next_cycle();
        clear_inputs();
        m_rdata_valid = 1'b1;
        i_rdata_ack   = 1'b1;
        #1;
        next_cycle();
        clear_inputs();
        // Store while inst waits during REQ adds the third conflict cycle
        d_wen   = 1'b1;
        d_addr  = 32'h0000_2008;
        d_wstrb = 4'b0010;
        #1;
        next_cycle();
        i_req_valid = 1'b1;
        m_req_ack   = 1'b1;
        #1;
        chk1("t7.d_req_ack", d_req_ack, 1'b1);
        next_cycle();
        clear_inputs();
        #1;
        chk32("t7.inst_grant_cnt", inst_grant_cnt, 32'd4);
        chk32("t7.data_grant_cnt", data_grant_cnt, 32'd2);
        chk32("t7.conflict_cnt",   conflict_cnt, 32'd3);
        next_cycle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
